// File: rtl/cjb_const_unit_arb_v.sv
// Round-robin arbiter sharing one 8-bit constant unit between requesters A and B.
// Optional WAIT_ACK abort timer enabled by defining CJB_ARB_TIMEOUT_EN.
module cjb_const_unit_arb_v #(
  parameter int TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_a,
  input  logic [1:0] i_sel_a,
  input  logic       i_req_b,
  input  logic [1:0] i_sel_b,
  input  logic       i_ack,
  input  logic [7:0] i_const_result,
  input  logic [3:0] i_const_cnvz,
  output logic [1:0] o_func_sel,
  output logic       o_gnt_a,
  output logic       o_gnt_b,
  output logic [7:0] o_result,
  output logic [3:0] o_cnvz,
  output logic       o_valid,
  output logic       o_owner,
  output logic       o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_sel_q;
  logic       r_last;
  logic       r_gnt_a;
  logic       r_gnt_b;
  logic [7:0] r_result;
  logic [3:0] r_cnvz;
  logic       r_valid;
  logic       r_owner;
  logic       r_timeout;
  logic       w_any_req;
  logic       w_win_b;
  logic       w_abort;
  logic       w_done;

  assign w_any_req = i_req_a | i_req_b;
  // On a tie the requester not served last wins; r_last = 1 means B was served last.
  assign w_win_b   = i_req_b & (~i_req_a | ~r_last);

`ifdef CJB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= 8'd0;
    else if (r_state == S_ISSUE)
      r_cnt <= 8'd0;
    else if (r_state == S_WAIT && !i_ack)
      r_cnt <= r_cnt + 8'd1;
  end

  // Ack has precedence over the terminal count.
  assign w_abort = (r_state == S_WAIT) && !i_ack && (r_cnt == TO_LAST);
`else
  assign w_abort = 1'b0;
`endif

  assign w_done = (r_state == S_WAIT) && (i_ack || w_abort);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_func_sel = (r_state == S_IDLE) ? 2'b00 : r_sel_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel_q   <= 2'b00;
      r_last    <= 1'b1;
      r_gnt_a   <= 1'b0;
      r_gnt_b   <= 1'b0;
      r_result  <= 8'h00;
      r_cnvz    <= 4'h0;
      r_valid   <= 1'b0;
      r_owner   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_abort;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_a <= ~w_win_b;
            r_gnt_b <= w_win_b;
            r_owner <= w_win_b;
            r_sel_q <= w_win_b ? i_sel_b : i_sel_a;
          end
        end
        S_ISSUE: begin
          r_result <= i_const_result;
          r_cnvz   <= i_const_cnvz;
          r_valid  <= 1'b1;
        end
        S_WAIT: begin
          if (w_done) begin
            r_valid <= 1'b0;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_last  <= r_owner;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_gnt_a   = r_gnt_a;
  assign o_gnt_b   = r_gnt_b;
  assign o_result  = r_result;
  assign o_cnvz    = r_cnvz;
  assign o_valid   = r_valid;
  assign o_owner   = r_owner;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_cjb_const_unit_arb_v.sv
// Self-checking bench for cjb_const_unit_arb_v with an attached constant-unit model.
module tb_cjb_const_unit_arb_v;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, ack = 1'b0;
  logic [1:0] sel_a = 2'b00, sel_b = 2'b00;
  logic [7:0] const_result;
  logic [3:0] const_cnvz;
  logic [1:0] func_sel;
  logic       gnt_a, gnt_b, valid, owner, timeout;
  logic [7:0] result;
  logic [3:0] cnvz;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Shared constant unit: {result, C, N, V, Z}
  function automatic logic [11:0] unit(input logic [1:0] s);
    case (s)
      2'b00:   return {8'h00, 4'b0001};
      2'b01:   return {8'h55, 4'b0000};
      2'b10:   return {8'hAA, 4'b0100};
      default: return {8'hFF, 4'b0100};
    endcase
  endfunction

  assign {const_result, const_cnvz} = unit(func_sel);

  cjb_const_unit_arb_v #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_a(req_a), .i_sel_a(sel_a),
    .i_req_b(req_b), .i_sel_b(sel_b),
    .i_ack(ack),
    .i_const_result(const_result), .i_const_cnvz(const_cnvz),
    .o_func_sel(func_sel), .o_gnt_a(gnt_a), .o_gnt_b(gnt_b),
    .o_result(result), .o_cnvz(cnvz), .o_valid(valid),
    .o_owner(owner), .o_timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({gnt_a, gnt_b, valid, owner, timeout, result, cnvz, func_sel} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {gnt_a, gnt_b, valid, owner, timeout, result, cnvz, func_sel});
    end
    rst = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({gnt_a, gnt_b, valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ack_ignored got=%b exp=000", {gnt_a, gnt_b, valid});
    end
  endtask

  task automatic test_single_a();
    req_a = 1'b1; sel_a = 2'b10;
    tick();
    req_a = 1'b0; sel_a = 2'b01;
    checks++;
    if ({gnt_a, gnt_b, owner, valid, func_sel} !== 6'b100010) begin
      errors++;
      $display("FAIL a_grant got=%b exp=100010", {gnt_a, gnt_b, owner, valid, func_sel});
    end
    tick();
    checks++;
    if ({valid, result, cnvz, owner, func_sel} !== {1'b1, 8'hAA, 4'b0100, 1'b0, 2'b10}) begin
      errors++;
      $display("FAIL a_result got=%h exp=%h", {valid, result, cnvz, owner, func_sel},
               {1'b1, 8'hAA, 4'b0100, 1'b0, 2'b10});
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({valid, gnt_a, gnt_b, func_sel} !== 5'b00000) begin
      errors++;
      $display("FAIL a_ack got=%b exp=00000", {valid, gnt_a, gnt_b, func_sel});
    end
  endtask

  task automatic test_single_b();
    req_b = 1'b1; sel_b = 2'b00;
    tick();
    req_b = 1'b0;
    checks++;
    if ({gnt_a, gnt_b, owner} !== 3'b011) begin
      errors++;
      $display("FAIL b_grant got=%b exp=011", {gnt_a, gnt_b, owner});
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({valid, result, cnvz, owner} !== {1'b1, 8'h00, 4'b0001, 1'b1}) begin
        errors++;
        $display("FAIL b_hold cyc=%0d got=%h exp=%h", i, {valid, result, cnvz, owner},
                 {1'b1, 8'h00, 4'b0001, 1'b1});
      end
      if (i == 2) ack = 1'b1;
      tick();
    end
    ack = 1'b0;
    checks++;
    if ({valid, gnt_b, func_sel} !== 4'b0000) begin
      errors++;
      $display("FAIL b_ack got=%b exp=0000", {valid, gnt_b, func_sel});
    end
  endtask

  task automatic test_alternate();
    logic exp_b;
    req_a = 1'b1; sel_a = 2'b11;
    req_b = 1'b1; sel_b = 2'b01;
    for (int i = 0; i < 4; i++) begin
      exp_b = (i % 2) == 1;
      tick();
      checks++;
      if ({gnt_a, gnt_b, owner} !== {~exp_b, exp_b, exp_b}) begin
        errors++;
        $display("FAIL alt_grant n=%0d got=%b exp=%b", i, {gnt_a, gnt_b, owner},
                 {~exp_b, exp_b, exp_b});
      end
      tick();
      checks++;
      if ({valid, result} !== {1'b1, (exp_b ? 8'h55 : 8'hFF)}) begin
        errors++;
        $display("FAIL alt_result n=%0d got=%h exp=%h", i, {valid, result},
                 {1'b1, (exp_b ? 8'h55 : 8'hFF)});
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if ({valid, gnt_a, gnt_b} !== 3'b000) begin
        errors++;
        $display("FAIL alt_release n=%0d got=%b exp=000", i, {valid, gnt_a, gnt_b});
      end
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_a = 1'b1; sel_a = 2'b01;
    tick();
    req_a = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_valid_before got=%b exp=1", valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt_a, gnt_b, valid, owner, timeout, result, cnvz, func_sel} !== 19'd0) begin
      errors++;
      $display("FAIL mid_async_reset got=%h exp=0",
               {gnt_a, gnt_b, valid, owner, timeout, result, cnvz, func_sel});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({valid, gnt_a, gnt_b} !== 3'b000) begin
        errors++;
        $display("FAIL mid_no_stale cyc=%0d got=%b exp=000", i, {valid, gnt_a, gnt_b});
      end
    end
  endtask

  task automatic test_timeout();
    int nv = 0;
    int tp = 0;
    req_a = 1'b1; sel_a = 2'b10;
    req_b = 1'b1; sel_b = 2'b01;
    tick();
    checks++;
    if (gnt_a !== 1'b1) begin
      errors++;
      $display("FAIL to_first_grant got=%b exp=1", gnt_a);
    end
`ifdef CJB_ARB_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid) nv++;
      if (timeout) tp++;
      if (!valid) break;
    end
    checks++;
    if (nv != 4 || tp != 1 || timeout !== 1'b1 || gnt_a !== 1'b0) begin
      errors++;
      $display("FAIL to_abort got valid_cycles=%0d pulses=%0d to=%b gnt_a=%b exp 4 1 1 0",
               nv, tp, timeout, gnt_a);
    end
    tick();
    checks++;
    if ({gnt_a, gnt_b, timeout} !== 3'b010) begin
      errors++;
      $display("FAIL to_next_grant got=%b exp=010", {gnt_a, gnt_b, timeout});
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
`else
    for (int i = 0; i < 101; i++) begin
      tick();
      if (valid) nv++;
      if (timeout) tp++;
    end
    checks++;
    if (nv != 101 || tp != 0) begin
      errors++;
      $display("FAIL hold_no_timeout got valid_cycles=%0d pulses=%0d exp 101 0", nv, tp);
    end
    req_a = 1'b0; req_b = 1'b0;
`endif
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({valid, gnt_a, gnt_b} !== 3'b000) begin
      errors++;
      $display("FAIL to_release got=%b exp=000", {valid, gnt_a, gnt_b});
    end
  endtask

  // Transaction-level reference: winner by round-robin rule, data from unit table.
  task automatic test_random();
    logic       m_last_b;
    logic       win_b;
    logic [1:0] exp_sel;
    logic [11:0] exp_data;
    int         d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last_b = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_a = 1'b0; req_b = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({gnt_a, gnt_b, valid} !== 3'b000) begin
          errors++;
          $display("FAIL rnd_idle n=%0d got=%b exp=000", n, {gnt_a, gnt_b, valid});
        end
      end
      do begin
        req_a = 1'($urandom);
        req_b = 1'($urandom);
      end while (!req_a && !req_b);
      sel_a = 2'($urandom);
      sel_b = 2'($urandom);
      if (req_a && req_b) win_b = !m_last_b;
      else                win_b = req_b;
      exp_sel  = win_b ? sel_b : sel_a;
      exp_data = unit(exp_sel);
      tick();
      checks++;
      if ({gnt_a, gnt_b, owner, func_sel} !== {~win_b, win_b, win_b, exp_sel}) begin
        errors++;
        $display("FAIL rnd_grant n=%0d got=%b exp=%b", n, {gnt_a, gnt_b, owner, func_sel},
                 {~win_b, win_b, win_b, exp_sel});
      end
      req_a = 1'($urandom); req_b = 1'($urandom);
      sel_a = 2'($urandom); sel_b = 2'($urandom);
      tick();
      d = $urandom_range(0, 2);
      for (int k = 0; k <= d; k++) begin
        req_a = 1'($urandom); req_b = 1'($urandom);
        sel_a = 2'($urandom); sel_b = 2'($urandom);
        checks++;
        if ({valid, result, cnvz, owner, gnt_a, gnt_b} !==
            {1'b1, exp_data, win_b, ~win_b, win_b}) begin
          errors++;
          $display("FAIL rnd_data n=%0d k=%0d got=%h exp=%h", n, k,
                   {valid, result, cnvz, owner, gnt_a, gnt_b},
                   {1'b1, exp_data, win_b, ~win_b, win_b});
        end
        if (k == d) ack = 1'b1;
        tick();
      end
      ack = 1'b0;
      req_a = 1'b0; req_b = 1'b0;
      checks++;
      if ({valid, gnt_a, gnt_b} !== 3'b000) begin
        errors++;
        $display("FAIL rnd_release n=%0d got=%b exp=000", n, {valid, gnt_a, gnt_b});
      end
      m_last_b = win_b;
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_single_b();
    test_alternate();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cjb_const_unit_arb_v.md
CJB_CONST_UNIT_ARB_V -- requirements
Module: cjb_const_unit_arb_v

Interface
REQ-001 Parameter: TIMEOUT, default 15, WAIT_ACK cycles before abort (used only with CJB_ARB_TIMEOUT_EN); legal range 1..255.
REQ-002 Clock  input  1  single clock, all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Req_A  input  1  requester A wants a constant.
REQ-005 Sel_A  input  2  requester A function select.
REQ-006 Req_B  input  1  requester B wants a constant.
REQ-007 Sel_B  input  2  requester B function select.
REQ-008 Ack  input  1  consumer accepts Result/CNVZ.
REQ-009 Const_Result  input  8  result from shared 8-bit constant unit.
REQ-010 Const_CNVZ  input  4  {C,N,V,Z} flags from shared constant unit.
REQ-011 Func_Sel  output  2  select driven to shared constant unit.
REQ-012 Gnt_A / Gnt_B  output  1 each  grant, one-hot or both low.
REQ-013 Result  output  8  registered captured result.
REQ-014 CNVZ  output  4  registered captured flags.
REQ-015 Valid  output  1  Result/CNVZ valid, held until Ack.
REQ-016 Owner  output  1  0 = A, 1 = B; source of the current transaction.
REQ-017 Timeout  output  1  one-cycle pulse on abort (CJB_ARB_TIMEOUT_EN only).

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT_ACK; all outputs registered except Func_Sel, which is decoded from registered state and Sel_Q.
REQ-019 IDLE: if any Req is high at an edge, arbitrate, latch the winner's Sel into Sel_Q, set Owner and the matching Gnt, and go to ISSUE.
REQ-020 Arbitration: round-robin; a sole requester wins; on a tie the requester not served last wins; after reset A has priority.
REQ-021 ISSUE lasts exactly one cycle: Func_Sel = Sel_Q; at the edge, Const_Result -> Result, Const_CNVZ -> CNVZ, Valid <= 1, go to WAIT_ACK.
REQ-022 WAIT_ACK: Valid = 1, Func_Sel = Sel_Q; Result/CNVZ stable; on an edge with Ack = 1, clear Valid and Gnt, update the last-served pointer, go to IDLE.
REQ-023 Func_Sel = 2'b00 in IDLE.
REQ-024 Latency: Req sampled at edge n -> Gnt high after n; Valid high after n+1; earliest re-grant is the edge after the Ack edge (one IDLE cycle minimum).
REQ-025 Ack outside WAIT_ACK is ignored; Req/Sel changes after the grant edge do not affect the transaction.
REQ-026 Dropping Req during ISSUE/WAIT_ACK does not cancel the transaction.
REQ-027 Gnt_A and Gnt_B are never both high.

Reset
REQ-028 Reset forces IDLE immediately, regardless of current state.
REQ-029 Reset values: Gnt_A = Gnt_B = 0, Valid = 0, Result = 8'h00, CNVZ = 4'h0, Owner = 0, Timeout = 0, Sel_Q = 2'b00, last-served pointer = B (so A wins the first tie), timeout counter = 0.
REQ-030 Reset mid-transaction discards it; no Valid is produced for it after release.

Configuration
REQ-031 Macro CJB_ARB_TIMEOUT_EN defined: an 8-bit counter clears on WAIT_ACK entry and increments each WAIT_ACK cycle without Ack; when it reaches TIMEOUT without Ack, clear Valid and Gnt, pulse Timeout for one cycle, update the last-served pointer, and go to IDLE.
REQ-032 When Ack and the timeout terminal count coincide, Ack wins and Timeout stays 0.
REQ-033 Macro CJB_ARB_TIMEOUT_EN undefined: no counter; WAIT_ACK persists until Ack; Timeout is tied 0; TIMEOUT is unused.

Verification
REQ-034 Req_A = 1, Sel_A = 2'b10, unit model attached -> Gnt_A after 1 edge, Valid after 2, Result = 8'hAA, CNVZ = 4'b0100, Owner = 0.
REQ-035 Req_B = 1, Sel_B = 2'b00 -> Result = 8'h00, CNVZ = 4'b0001, Owner = 1; Ack three cycles later -> Valid low on the Ack edge, state IDLE.
REQ-036 Both Req held continuously after reset, Sel_A = 2'b11, Sel_B = 2'b01, Ack one cycle after each Valid -> grants A, B, A, B; Results 8'hFF, 8'h55, 8'hFF, 8'h55; grants never overlap.
REQ-037 Reset asserted during WAIT_ACK with Valid = 1 -> all outputs reach reset values without a clock edge; no stale Valid after release.
REQ-038 CJB_ARB_TIMEOUT_EN defined, TIMEOUT = 4, Ack held 0 -> Valid drops after 4 WAIT_ACK cycles, single Timeout pulse, other requester granted next; without the macro, Valid stays high for 100 cycles.
